// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    LEN_HI,
    LEN_LO,
    DATA,
    CSUM,
    DONE
  } state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int LEN_BYTES      = 2;

endpackage

// File: rtl/byte_packer.sv
// Big-endian 4-byte shift assembler; word_valid flags the byte that completes a word,
// with the full word presented combinationally alongside it.
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_valid
);

  localparam int IDX_W   = $clog2(BYTES_PER_WORD);
  localparam int SHIFT_W = 8 * (BYTES_PER_WORD - 1);

  logic [SHIFT_W-1:0] shift_q;
  logic [IDX_W-1:0]   idx_q;

  assign word_valid = byte_valid && (idx_q == IDX_W'(BYTES_PER_WORD - 1));
  assign word       = {shift_q, byte_in};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      idx_q   <= '0;
    end else if (clear) begin
      shift_q <= '0;
      idx_q   <= '0;
    end else if (byte_valid) begin
      shift_q <= {shift_q[SHIFT_W-9:0], byte_in};
      idx_q   <= word_valid ? '0 : idx_q + IDX_W'(1);
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream boot loader for the instruction memory; holds the CPU until loaded.
// Optional trailing XOR checksum byte is enabled by defining IMEM_LOADER_CSUM_EN.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int LEN_W = 8 * LEN_BYTES;

`ifdef IMEM_LOADER_CSUM_EN
  localparam state_t AFTER_DATA = CSUM;
`else
  localparam state_t AFTER_DATA = DONE;
`endif

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   word_idx_q;
  logic               ovf_q;
  logic               xfer;
  logic               data_byte;
  logic               len_zero;
  logic               last_word;
  logic               word_ovf;
  logic               word_valid;
  logic [31:0]        packed_word;
  logic               finish;
  logic               fin_err;
`ifdef IMEM_LOADER_CSUM_EN
  logic [7:0]         csum_q;
`else
  logic               last_q;
`endif

  // A byte offered alongside start is dropped so the new frame begins cleanly.
  assign in_ready  = (state_q != DONE);
  assign xfer      = in_valid && in_ready && !start;
  assign data_byte = (state_q == DATA) && xfer;
  assign len_zero  = ({len_q[LEN_W-9:0], in_data} == '0);
  assign last_word = word_valid && (word_idx_q == len_q - LEN_W'(1));
  assign word_ovf  = ((word_idx_q >> ADDR_W) != '0);

  byte_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (start),
    .byte_valid (data_byte),
    .byte_in    (in_data),
    .word       (packed_word),
    .word_valid (word_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= LEN_HI;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = LEN_HI;
    end else begin
      case (state_q)
        LEN_HI:  if (xfer) state_d = LEN_LO;
        LEN_LO:  if (xfer) state_d = len_zero ? AFTER_DATA : DATA;
        DATA:    if (last_word) state_d = AFTER_DATA;
        CSUM:    if (xfer) state_d = DONE;
        DONE:    state_d = DONE;
        default: state_d = LEN_HI;
      endcase
    end
  end

  // Without a checksum the status lands one cycle after the last write, via last_q.
  always_comb begin
    finish  = 1'b0;
    fin_err = ovf_q;
`ifdef IMEM_LOADER_CSUM_EN
    finish  = (state_q == CSUM) && xfer;
    fin_err = ovf_q || (in_data != csum_q);
`else
    finish  = ((state_q == LEN_LO) && xfer && len_zero) || last_q;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q        <= '0;
      word_idx_q   <= '0;
      ovf_q        <= 1'b0;
      im_we        <= 1'b0;
      im_addr      <= '0;
      im_wdata     <= '0;
      words_loaded <= '0;
      done         <= 1'b0;
      error        <= 1'b0;
      cpu_hold     <= 1'b1;
`ifdef IMEM_LOADER_CSUM_EN
      csum_q       <= '0;
`else
      last_q       <= 1'b0;
`endif
    end else if (start) begin
      len_q        <= '0;
      word_idx_q   <= '0;
      ovf_q        <= 1'b0;
      im_we        <= 1'b0;
      im_addr      <= '0;
      im_wdata     <= '0;
      words_loaded <= '0;
      done         <= 1'b0;
      error        <= 1'b0;
      cpu_hold     <= 1'b1;
`ifdef IMEM_LOADER_CSUM_EN
      csum_q       <= '0;
`else
      last_q       <= 1'b0;
`endif
    end else begin
      im_we <= 1'b0;
`ifndef IMEM_LOADER_CSUM_EN
      last_q <= 1'b0;
`endif
      if (((state_q == LEN_HI) || (state_q == LEN_LO)) && xfer)
        len_q <= {len_q[LEN_W-9:0], in_data};
`ifdef IMEM_LOADER_CSUM_EN
      if (data_byte)
        csum_q <= csum_q ^ in_data;
`endif
      // Words beyond the memory depth are consumed but never written.
      if (word_valid) begin
        word_idx_q <= word_idx_q + LEN_W'(1);
        if (word_ovf) begin
          ovf_q <= 1'b1;
        end else begin
          im_we        <= 1'b1;
          im_addr      <= word_idx_q[ADDR_W-1:0];
          im_wdata     <= packed_word;
          words_loaded <= words_loaded + (ADDR_W + 1)'(1);
        end
`ifndef IMEM_LOADER_CSUM_EN
        if (last_word)
          last_q <= 1'b1;
`endif
      end
      if (finish) begin
        done     <= 1'b1;
        error    <= fin_err;
        cpu_hold <= fin_err;
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader: a default-depth instance plus a
// 4-word instance for overflow. Checksum scenarios compile in with IMEM_LOADER_CSUM_EN.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, in_valid;
  logic [7:0]  in_data;
  logic        in_ready, im_we, cpu_hold, done, error;
  logic [7:0]  im_addr;
  logic [31:0] im_wdata;
  logic [8:0]  words_loaded;

  logic        o_start, o_valid;
  logic [7:0]  o_data;
  logic        o_ready, o_we, o_hold, o_done, o_error;
  logic [1:0]  o_addr;
  logic [31:0] o_wdata;
  logic [2:0]  o_words;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  logic [7:0]  wa[$];
  logic [31:0] wd[$];
  int          wc[$];
  int          bc[$];
  int          done_cyc;
  logic        done_prev = 1'b0;
  logic [1:0]  o_wa[$];
  logic [31:0] o_wd[$];

  always #5 clk = ~clk;

  imem_loader #(.ADDR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
    .cpu_hold(cpu_hold), .done(done), .error(error), .words_loaded(words_loaded)
  );

  imem_loader #(.ADDR_W(2)) dut_small (
    .clk(clk), .rst_n(rst_n), .start(o_start), .in_valid(o_valid), .in_data(o_data),
    .in_ready(o_ready), .im_we(o_we), .im_addr(o_addr), .im_wdata(o_wdata),
    .cpu_hold(o_hold), .done(o_done), .error(o_error), .words_loaded(o_words)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Inputs change #1 after posedge, so everything here is stable at negedge.
  always @(negedge clk) begin
    if (in_valid && in_ready && !start) bc.push_back(cyc);
    if (im_we) begin
      wa.push_back(im_addr);
      wd.push_back(im_wdata);
      wc.push_back(cyc);
    end
    if (done && !done_prev) done_cyc = cyc;
    done_prev = done;
    if (o_we) begin
      o_wa.push_back(o_addr);
      o_wd.push_back(o_wdata);
    end
  end

  task automatic send_byte(input bit sel, input logic [7:0] b);
    int guard;
    guard = 0;
    if (sel) begin o_valid = 1'b1; o_data = b; end
    else     begin in_valid = 1'b1; in_data = b; end
    @(negedge clk);
    while (!(sel ? o_ready : in_ready) && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL ready_timeout: in_ready stayed 0, required 1");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    o_valid  = 1'b0;
  endtask

  task automatic send_frame(input bit sel, input logic [15:0] n,
                            input logic [31:0] words [8], input bit gap);
    logic [7:0] b;
`ifdef IMEM_LOADER_CSUM_EN
    logic [7:0] x;
    x = 8'h00;
`endif
    send_byte(sel, n[15:8]);
    if (gap) begin @(posedge clk); #1; end
    send_byte(sel, n[7:0]);
    if (gap) begin @(posedge clk); #1; end
    for (int i = 0; i < int'(n); i++) begin
      for (int j = 0; j < 4; j++) begin
        b = words[i][31-8*j -: 8];
`ifdef IMEM_LOADER_CSUM_EN
        x = x ^ b;
`endif
        send_byte(sel, b);
        if (gap) begin @(posedge clk); #1; end
      end
    end
`ifdef IMEM_LOADER_CSUM_EN
    send_byte(sel, x);
`endif
  endtask

  task automatic clear_logs();
    wa.delete(); wd.delete(); wc.delete(); bc.delete();
    o_wa.delete(); o_wd.delete();
    done_cyc = -1;
  endtask

  task automatic pulse_start(input bit sel);
    if (sel) o_start = 1'b1; else start = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
    o_start = 1'b0;
    clear_logs();
  endtask

  task automatic settle();
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    o_start = 1'b0; o_valid = 1'b0; o_data = 8'h00;
    clear_logs();
    repeat (3) @(posedge clk);
    #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_in_ready: got %b want 1", in_ready); end
    vectors++; if (im_we !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_im_we: got %b want 0", im_we); end
    vectors++; if (im_addr !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_im_addr: got %h want 00", im_addr); end
    vectors++; if (im_wdata !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_im_wdata: got %h want 0", im_wdata); end
    vectors++; if (cpu_hold !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_cpu_hold: got %b want 1", cpu_hold); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_done: got %b want 0", done); end
    vectors++; if (error !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_error: got %b want 0", error); end
    vectors++; if (words_loaded !== 9'd0) begin miscompares++; $display("[TB] FAIL reset_words: got %0d want 0", words_loaded); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic check_basic_result(input string tag);
    vectors++; if (wa.size() != 2) begin miscompares++; $display("[TB] FAIL %s_write_count: got %0d want 2", tag, wa.size()); end
    if (wa.size() == 2 && bc.size() >= 10) begin
      vectors++; if (wa[0] !== 8'd0) begin miscompares++; $display("[TB] FAIL %s_addr0: got %h want 00", tag, wa[0]); end
      vectors++; if (wd[0] !== 32'h20080005) begin miscompares++; $display("[TB] FAIL %s_data0: got %h want 20080005", tag, wd[0]); end
      vectors++; if (wa[1] !== 8'd1) begin miscompares++; $display("[TB] FAIL %s_addr1: got %h want 01", tag, wa[1]); end
      vectors++; if (wd[1] !== 32'h20090007) begin miscompares++; $display("[TB] FAIL %s_data1: got %h want 20090007", tag, wd[1]); end
      vectors++; if (wc[0] != bc[5] + 1) begin miscompares++; $display("[TB] FAIL %s_we0_timing: got cycle %0d want %0d", tag, wc[0], bc[5] + 1); end
      vectors++; if (wc[1] != bc[9] + 1) begin miscompares++; $display("[TB] FAIL %s_we1_timing: got cycle %0d want %0d", tag, wc[1], bc[9] + 1); end
`ifdef IMEM_LOADER_CSUM_EN
      vectors++; if (done_cyc != bc[10] + 1) begin miscompares++; $display("[TB] FAIL %s_done_timing: got cycle %0d want %0d", tag, done_cyc, bc[10] + 1); end
`else
      vectors++; if (done_cyc != bc[9] + 2) begin miscompares++; $display("[TB] FAIL %s_done_timing: got cycle %0d want %0d", tag, done_cyc, bc[9] + 2); end
`endif
    end
    vectors++; if (words_loaded !== 9'd2) begin miscompares++; $display("[TB] FAIL %s_words: got %0d want 2", tag, words_loaded); end
    vectors++; if (done !== 1'b1) begin miscompares++; $display("[TB] FAIL %s_done: got %b want 1", tag, done); end
    vectors++; if (cpu_hold !== 1'b0) begin miscompares++; $display("[TB] FAIL %s_cpu_hold: got %b want 0", tag, cpu_hold); end
    vectors++; if (error !== 1'b0) begin miscompares++; $display("[TB] FAIL %s_error: got %b want 0", tag, error); end
  endtask

  task automatic test_basic_load();
    logic [31:0] w [8];
    w = '{default: 32'h0};
    w[0] = 32'h20080005;
    w[1] = 32'h20090007;
    pulse_start(1'b0);
    vectors++; if (cpu_hold !== 1'b1) begin miscompares++; $display("[TB] FAIL start_cpu_hold: got %b want 1", cpu_hold); end
    send_frame(1'b0, 16'd2, w, 1'b0);
    settle();
    check_basic_result("basic");
  endtask

  task automatic test_start_clears();
    pulse_start(1'b0);
    vectors++; if (done !== 1'b0) begin miscompares++; $display("[TB] FAIL start_done_clear: got %b want 0", done); end
    vectors++; if (cpu_hold !== 1'b1) begin miscompares++; $display("[TB] FAIL start_hold_set: got %b want 1", cpu_hold); end
    vectors++; if (words_loaded !== 9'd0) begin miscompares++; $display("[TB] FAIL start_words_clear: got %0d want 0", words_loaded); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL start_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_empty_image();
    logic [31:0] w [8];
    w = '{default: 32'h0};
    pulse_start(1'b0);
    send_frame(1'b0, 16'd0, w, 1'b0);
    settle();
    vectors++; if (wa.size() != 0) begin miscompares++; $display("[TB] FAIL empty_writes: got %0d want 0", wa.size()); end
    vectors++; if (done !== 1'b1) begin miscompares++; $display("[TB] FAIL empty_done: got %b want 1", done); end
    vectors++; if (cpu_hold !== 1'b0) begin miscompares++; $display("[TB] FAIL empty_cpu_hold: got %b want 0", cpu_hold); end
    if (bc.size() > 0) begin
      vectors++; if (done_cyc != bc[bc.size()-1] + 1) begin miscompares++; $display("[TB] FAIL empty_done_timing: got cycle %0d want %0d", done_cyc, bc[bc.size()-1] + 1); end
    end
  endtask

  task automatic test_stalled_stream();
    logic [31:0] w [8];
    w = '{default: 32'h0};
    w[0] = 32'h20080005;
    w[1] = 32'h20090007;
    pulse_start(1'b0);
    send_frame(1'b0, 16'd2, w, 1'b1);
    settle();
    check_basic_result("stalled");
  endtask

  task automatic test_reset_mid_load();
    logic [31:0] w [8];
    w = '{default: 32'h0};
    w[0] = 32'hAABBCCDD;
    pulse_start(1'b0);
    send_byte(1'b0, 8'h00);
    send_byte(1'b0, 8'h01);
    send_byte(1'b0, 8'h20);
    send_byte(1'b0, 8'h08);
    send_byte(1'b0, 8'h00);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    settle();
    vectors++; if (wa.size() != 0) begin miscompares++; $display("[TB] FAIL midreset_writes: got %0d want 0", wa.size()); end
    vectors++; if (words_loaded !== 9'd0) begin miscompares++; $display("[TB] FAIL midreset_words: got %0d want 0", words_loaded); end
    vectors++; if (cpu_hold !== 1'b1) begin miscompares++; $display("[TB] FAIL midreset_cpu_hold: got %b want 1", cpu_hold); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("[TB] FAIL midreset_done: got %b want 0", done); end
    clear_logs();
    send_frame(1'b0, 16'd1, w, 1'b0);
    settle();
    vectors++; if (wa.size() != 1) begin miscompares++; $display("[TB] FAIL reload_writes: got %0d want 1", wa.size()); end
    if (wa.size() == 1) begin
      vectors++; if (wa[0] !== 8'd0) begin miscompares++; $display("[TB] FAIL reload_addr: got %h want 00", wa[0]); end
      vectors++; if (wd[0] !== 32'hAABBCCDD) begin miscompares++; $display("[TB] FAIL reload_data: got %h want aabbccdd", wd[0]); end
    end
    vectors++; if (done !== 1'b1) begin miscompares++; $display("[TB] FAIL reload_done: got %b want 1", done); end
    vectors++; if (cpu_hold !== 1'b0) begin miscompares++; $display("[TB] FAIL reload_cpu_hold: got %b want 0", cpu_hold); end
  endtask

  task automatic test_overflow();
    logic [31:0] w [8];
    logic [31:0] exp;
    w = '{default: 32'h0};
    w[0] = 32'h10203040;
    w[1] = 32'h11213141;
    w[2] = 32'h12223242;
    w[3] = 32'h13233343;
    w[4] = 32'h14243444;
    pulse_start(1'b1);
    send_frame(1'b1, 16'd5, w, 1'b0);
    settle();
    vectors++; if (o_wa.size() != 4) begin miscompares++; $display("[TB] FAIL ovf_write_count: got %0d want 4", o_wa.size()); end
    if (o_wa.size() == 4) begin
      for (int k = 0; k < 4; k++) begin
        exp = 32'h10203040 + 32'h01010101 * k;
        vectors++; if (o_wa[k] !== 2'(k)) begin miscompares++; $display("[TB] FAIL ovf_addr%0d: got %0d want %0d", k, o_wa[k], k); end
        vectors++; if (o_wd[k] !== exp) begin miscompares++; $display("[TB] FAIL ovf_data%0d: got %h want %h", k, o_wd[k], exp); end
      end
    end
    vectors++; if (o_words !== 3'd4) begin miscompares++; $display("[TB] FAIL ovf_words: got %0d want 4", o_words); end
    vectors++; if (o_done !== 1'b1) begin miscompares++; $display("[TB] FAIL ovf_done: got %b want 1", o_done); end
    vectors++; if (o_error !== 1'b1) begin miscompares++; $display("[TB] FAIL ovf_error: got %b want 1", o_error); end
    vectors++; if (o_hold !== 1'b1) begin miscompares++; $display("[TB] FAIL ovf_cpu_hold: got %b want 1", o_hold); end
  endtask

`ifdef IMEM_LOADER_CSUM_EN
  task automatic test_checksum();
    pulse_start(1'b0);
    send_byte(1'b0, 8'h00); send_byte(1'b0, 8'h01);
    send_byte(1'b0, 8'h01); send_byte(1'b0, 8'h02);
    send_byte(1'b0, 8'h03); send_byte(1'b0, 8'h04);
    send_byte(1'b0, 8'h04);
    settle();
    vectors++; if (done !== 1'b1) begin miscompares++; $display("[TB] FAIL csum_ok_done: got %b want 1", done); end
    vectors++; if (error !== 1'b0) begin miscompares++; $display("[TB] FAIL csum_ok_error: got %b want 0", error); end
    vectors++; if (cpu_hold !== 1'b0) begin miscompares++; $display("[TB] FAIL csum_ok_cpu_hold: got %b want 0", cpu_hold); end
    if (bc.size() == 7) begin
      vectors++; if (done_cyc != bc[6] + 1) begin miscompares++; $display("[TB] FAIL csum_done_timing: got cycle %0d want %0d", done_cyc, bc[6] + 1); end
    end
    pulse_start(1'b0);
    send_byte(1'b0, 8'h00); send_byte(1'b0, 8'h01);
    send_byte(1'b0, 8'h01); send_byte(1'b0, 8'h02);
    send_byte(1'b0, 8'h03); send_byte(1'b0, 8'h04);
    send_byte(1'b0, 8'h05);
    settle();
    vectors++; if (done !== 1'b1) begin miscompares++; $display("[TB] FAIL csum_bad_done: got %b want 1", done); end
    vectors++; if (error !== 1'b1) begin miscompares++; $display("[TB] FAIL csum_bad_error: got %b want 1", error); end
    vectors++; if (cpu_hold !== 1'b1) begin miscompares++; $display("[TB] FAIL csum_bad_cpu_hold: got %b want 1", cpu_hold); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_load();
    test_start_clears();
    test_empty_image();
    test_stalled_stream();
    test_reset_mid_load();
    test_overflow();
`ifdef IMEM_LOADER_CSUM_EN
    test_checksum();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Byte-stream boot loader that sits directly upstream of the MIPS instruction memory. It fills the instruction memory at run time instead of relying on a simulator-only hex preload. It accepts a framed byte stream through a valid/ready handshake, packs the bytes big-endian into 32-bit instruction words, and writes them to consecutive word addresses from 0. It holds the CPU (`cpu_hold`) until the image has loaded without error.

## Interface
- `ADDR_W`, 8: instruction-memory word-address width; depth is 2^ADDR_W words.
- `clk` input 1: sole clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: single-cycle pulse that restarts a load from any state.
- `in_valid` input 1: `in_data` is valid this cycle.
- `in_data` input 8: stream byte.
- `in_ready` output 1: loader accepts a byte this cycle. Reset value 1.
- `im_we` output 1: instruction-memory write strobe, one cycle per word. Reset value 0.
- `im_addr` output ADDR_W: word address for the write. Reset value 0.
- `im_wdata` output 32: instruction word. Reset value 0.
- `cpu_hold` output 1: keeps the CPU stalled. Reset value 1.
- `done` output 1: load finished. Sticky until `start` or reset. Reset value 0.
- `error` output 1: overflow or checksum failure. Sticky until `start` or reset. Reset value 0.
- `words_loaded` output ADDR_W+1: count of words actually written. Reset value 0.

## Operation
- Frame format:
  - 2-byte word count N, big-endian.
  - Then 4N data bytes, MSB of each word first.
  - Then 1 checksum byte, only when checksums are enabled (see Configuration).
- A byte transfers when `in_valid && in_ready`. `in_ready` is 1 in states LEN_HI, LEN_LO, DATA and CSUM, and 0 in DONE.
- State machine:
  - LEN_HI: on transfer, latch N[15:8], go to LEN_LO.
  - LEN_LO: on transfer, latch N[7:0]. If N==0 go to CSUM (checksum enabled) or DONE (disabled); otherwise go to DATA.
  - DATA: shift each byte into the packer. On the 4th byte of a word, register the write and increment the word counter. After word N: go to CSUM (enabled) or DONE.
  - CSUM: on transfer, compare the byte with the running checksum, then go to DONE.
  - DONE: holds. `start` goes to LEN_HI.
- Overflow: data words with index ≥ 2^ADDR_W are still consumed from the stream, but their `im_we` is suppressed. `words_loaded` saturates at 2^ADDR_W and `error` sets on entry to DONE.
- `cpu_hold` falls on entry to DONE only when `error` is 0. Otherwise it stays 1.
- `start` in any state:
  - Clears the counters, the packer, the checksum, `done` and `error`.
  - Sets `cpu_hold` to 1 and the state to LEN_HI.
  - Any byte offered in the same cycle is ignored.
- Reset mid-load: the partial word is discarded and no write issues. All outputs return to their reset values and loading restarts at LEN_HI.

## Timing
- A 4th data byte accepted at cycle t produces `im_we`=1 at t+1, together with `im_addr` and `im_wdata`. `im_addr` is 0 for the first word and increments by 1 per word.
- The last data word's `im_we` is at t+1. `done` rises and `cpu_hold` falls at t+2.
- With N==0 and checksums disabled, the second length byte is accepted at cycle c and `done` rises at c+1.
- With checksums enabled, the checksum byte is accepted at cycle c; `done`, and `error` if applicable, are valid at c+1.
- The loader accepts one byte per cycle with no bubbles. Gaps in `in_valid` stall it without losing state.

## Configuration
- `IMEM_LOADER_CSUM_EN` defined:
  - The CSUM state exists.
  - The checksum is the XOR of all data bytes; length bytes are excluded, and N==0 gives 8'h00.
  - A mismatch sets `error` and keeps `cpu_hold` at 1.
- Not defined: no CSUM state, no checksum register, and frames end after the last data byte.

## Structure
- Package `imem_loader_pkg` holds:
  - The state enum (LEN_HI, LEN_LO, DATA, CSUM, DONE).
  - Constants `BYTES_PER_WORD`=4 and `LEN_BYTES`=2.
- One sub-module, `byte_packer`: a 4-byte big-endian shift assembler with a byte index and a `word_valid` pulse.

## Test plan
- Basic load: bytes 00 02 20 08 00 05 20 09 00 07 → writes addr0=20080005 and addr1=20090007. Then `words_loaded`=2, `done`=1, `cpu_hold`=0, `error`=0.
- Empty image: bytes 00 00 → no `im_we`, `done`=1 one cycle after the second byte, `cpu_hold`=0.
- Stalled stream: the basic-load stream with `in_valid` toggled every other cycle → identical writes, with each write one cycle after its 4th byte.
- Reset mid-load: `rst_n` pulsed low after 00 01 20 08 00 → no write, `words_loaded`=0, `cpu_hold`=1. A following full frame loads correctly.
- Overflow: ADDR_W=2 with N=5 → writes to addr0–3 only, fifth word consumed, `words_loaded`=4, `error`=1, `cpu_hold`=1.
- Checksum (macro on): frame 00 01 01 02 03 04 with checksum 04 → `done`=1, `error`=0. Same frame with checksum 05 → `done`=1, `error`=1, `cpu_hold`=1.
